// File: rtl/tpg_crop_seq_ctrl.sv
// TPG/crop sequencer: programs the TPG over AXI4-Lite with one write outstanding, starts crop, then measures the stream.
// Valids are registered and held until ready. bready follows AW+W by 1 cycle. meas_* and frame_done lag their beat by 1 cycle.
module tpg_crop_seq_ctrl #(
  parameter int                ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] TPG_BASE   = '0,
  parameter int                INIT_DELAY = 10,
  parameter int                START_GAP  = 1,
  parameter int                DIM_W      = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DIM_W-1:0]  cfg_hsize,
  input  logic [DIM_W-1:0]  cfg_vsize,
  input  logic [7:0]        cfg_pattern,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic              ap_start,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tuser,
  input  logic              mon_tlast,
  output logic [DIM_W-1:0]  meas_width,
  output logic [DIM_W-1:0]  meas_height,
  output logic              frame_done,
  output logic              size_ok,
  output logic              busy,
  output logic              cfg_err
);

  typedef enum logic [2:0] {IDLE, WR_H, WR_W, WR_PAT, START, WR_CTRL, RUN, ERR} state_t;

  state_t            state;
  logic [31:0]       dly_cnt;
  logic [DIM_W-1:0]  hsize_l, vsize_l, pix_cnt, line_cnt;
  logic [7:0]        pattern_l;
  logic              aw_done, w_done, sof_seen;
  logic              aw_hs, w_hs, b_hs, mon_act, beat;

  assign m_axi_wstrb = 4'hF;
  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign b_hs    = m_axi_bvalid & m_axi_bready;
  assign mon_act = (state == START) || (state == WR_CTRL) || (state == RUN);
  assign beat    = mon_act & mon_tvalid & mon_tready;

  function automatic logic [DIM_W-1:0] sat_inc(input logic [DIM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      dly_cnt       <= '0;
      hsize_l       <= '0;
      vsize_l       <= '0;
      pattern_l     <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      ap_start      <= 1'b0;
      busy          <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b1;
          if (dly_cnt + 32'd1 >= 32'(INIT_DELAY)) begin
            hsize_l       <= cfg_hsize;
            vsize_l       <= cfg_vsize;
            pattern_l     <= cfg_pattern;
            m_axi_awaddr  <= TPG_BASE + ADDR_W'(8'h10);
            m_axi_wdata   <= 32'(cfg_vsize);
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WR_H;
          end else begin
            dly_cnt <= dly_cnt + 32'd1;
          end
        end
        WR_H, WR_W, WR_PAT, WR_CTRL: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs) && !m_axi_bready)
            m_axi_bready <= 1'b1;
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              // ap_start is left as-is: only an error after WR_PAT sees it high
              state   <= ERR;
              cfg_err <= 1'b1;
              busy    <= 1'b0;
            end else begin
              case (state)
                WR_H: begin
                  m_axi_awaddr  <= TPG_BASE + ADDR_W'(8'h18);
                  m_axi_wdata   <= 32'(hsize_l);
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= WR_W;
                end
                WR_W: begin
                  m_axi_awaddr  <= TPG_BASE + ADDR_W'(8'h20);
                  m_axi_wdata   <= {24'h0, pattern_l};
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= WR_PAT;
                end
                WR_PAT: begin
                  ap_start <= 1'b1;
                  dly_cnt  <= '0;
                  state    <= START;
                end
                default: begin
                  busy  <= 1'b0;
                  state <= RUN;
                end
              endcase
            end
          end
        end
        START: begin
          if (dly_cnt + 32'd1 >= 32'(START_GAP)) begin
            m_axi_awaddr  <= TPG_BASE;
            m_axi_wdata   <= 32'h81;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= WR_CTRL;
          end else begin
            dly_cnt <= dly_cnt + 32'd1;
          end
        end
        RUN: busy <= 1'b0;
        default: begin
          busy          <= 1'b0;
          m_axi_awvalid <= 1'b0;
          m_axi_wvalid  <= 1'b0;
          m_axi_bready  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      sof_seen    <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      frame_done  <= 1'b0;
      size_ok     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (beat) begin
        if (mon_tlast) begin
          meas_width <= sat_inc(pix_cnt);
          pix_cnt    <= '0;
        end else begin
          pix_cnt <= sat_inc(pix_cnt);
        end
        // an SOF beat closes the previous frame; meas_width still holds its last line
        if (mon_tuser) begin
          if (sof_seen) begin
            meas_height <= line_cnt;
            frame_done  <= 1'b1;
            size_ok     <= (meas_width == hsize_l) && (line_cnt == vsize_l);
          end
          sof_seen <= 1'b1;
          line_cnt <= {{(DIM_W-1){1'b0}}, mon_tlast};
        end else if (mon_tlast) begin
          line_cnt <= sat_inc(line_cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_tpg_crop_seq_ctrl.sv
// Bench for tpg_crop_seq_ctrl: scenario table for the AXI4-Lite config sequence, scoreboarded writes and frames.
// Hand-written sequences cover stream measurement and reset during a pending write.
module tb_tpg_crop_seq_ctrl;

  localparam int INIT_DELAY = 10;
  localparam int START_GAP  = 1;

  logic        aclk, aresetn;
  logic [15:0] cfg_hsize, cfg_vsize;
  logic [7:0]  cfg_pattern;
  logic [11:0] m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic        ap_start;
  logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
  logic [15:0] meas_width, meas_height;
  logic        frame_done, size_ok, busy, cfg_err;

  tpg_crop_seq_ctrl #(
    .ADDR_W(12), .TPG_BASE(12'h000), .INIT_DELAY(INIT_DELAY), .START_GAP(START_GAP), .DIM_W(16)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_hsize(cfg_hsize), .cfg_vsize(cfg_vsize), .cfg_pattern(cfg_pattern),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .ap_start(ap_start),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
    .meas_width(meas_width), .meas_height(meas_height), .frame_done(frame_done),
    .size_ok(size_ok), .busy(busy), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic [15:0] w;
    logic [15:0] h;
    logic        ok;
  } fd_t;

  typedef struct {
    logic [15:0] h, v;
    logic [7:0]  pat;
    int          aw_dly, w_dly, b_dly, err_idx;
    bit          exp_ap, exp_err;
  } row_t;

  wr_t         exp_q[$];
  fd_t         fd_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          fd_cnt = 0;
  bit          armed;
  logic [15:0] last_w, line_m, cur_h, cur_v;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // AXI4-Lite slave for one write: readies after the given delays, response after b_dly
  task automatic slave_write(input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp, output int waited, output int apc);
    logic [11:0] a0;
    logic [31:0] d0;
    wr_t         e;
    bit          aw_ok, w_ok, aw_go, w_go;
    int          c;
    waited = 0;
    apc = 0;
    while (!m_axi_awvalid && waited < 200) begin
      if (ap_start) apc++;
      @(negedge aclk);
      waited++;
    end
    chk("awvalid_seen", m_axi_awvalid, 1);
    if (!m_axi_awvalid) return;
    chk("wvalid_with_awvalid", m_axi_wvalid, 1);
    chk("busy_during_cfg", busy, 1);
    a0 = m_axi_awaddr;
    d0 = m_axi_wdata;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", a0, d0);
    end else begin
      e = exp_q.pop_front();
      chk("write_addr", a0, e.a);
      chk("write_data", d0, e.d);
    end
    aw_ok = 0; w_ok = 0; c = 0;
    while (!(aw_ok && w_ok) && c < 100) begin
      if (c > 0) begin
        if (!aw_ok) chk("aw_hold_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, a0});
        else        chk("aw_drop_after_hs", m_axi_awvalid, 0);
        if (!w_ok)  chk("w_hold_stable", {m_axi_wvalid, m_axi_wdata}, {1'b1, d0});
        else        chk("w_drop_after_hs", m_axi_wvalid, 0);
      end
      chk("bready_early", m_axi_bready, 0);
      aw_go = !aw_ok && (c >= aw_dly);
      w_go  = !w_ok && (c >= w_dly);
      m_axi_awready = aw_go;
      m_axi_wready  = w_go;
      @(posedge aclk);
      aw_ok = aw_ok | aw_go;
      w_ok  = w_ok | w_go;
      @(negedge aclk);
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      c++;
    end
    chk("bready_after_aw_w", m_axi_bready, 1);
    chk("valids_low_in_b", {m_axi_awvalid, m_axi_wvalid}, 0);
    c = 0;
    while (c < b_dly) begin
      @(negedge aclk);
      c++;
      chk("bready_hold", m_axi_bready, 1);
    end
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    @(posedge aclk);
    @(negedge aclk);
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    chk("bready_drop", m_axi_bready, 0);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_wstrb"}, m_axi_wstrb, 4'hF);
    chk(nm, {m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wvalid, m_axi_bready, ap_start,
             meas_width, meas_height, frame_done, size_ok, busy, cfg_err}, 0);
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
    repeat (2) @(negedge aclk);
    check_reset_outputs("reset_outputs");
  endtask

  // Called at a negedge with reset low: applies cfg, queues the expected writes, releases reset
  task automatic release_and_write(input row_t r);
    wr_t all[4];
    int  n, waited, apc, quiet;
    cfg_hsize = r.h; cfg_vsize = r.v; cfg_pattern = r.pat;
    all[0] = {12'h010, 16'h0, r.v};
    all[1] = {12'h018, 16'h0, r.h};
    all[2] = {12'h020, 24'h0, r.pat};
    all[3] = {12'h000, 32'h81};
    n = (r.err_idx >= 0) ? r.err_idx + 1 : 4;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(all[k]);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("busy_after_release", busy, 1);
    for (int k = 0; k < n; k++) begin
      slave_write(r.aw_dly, r.w_dly, r.b_dly, (k == r.err_idx) ? 2'b10 : 2'b00, waited, apc);
      if (k == 0) begin
        chk("init_delay_cycles", waited + 1, INIT_DELAY);
        cfg_hsize = ~r.h; cfg_vsize = ~r.v; cfg_pattern = ~r.pat;
      end
      if (k < 2) chk("ap_start_low_in_cfg", ap_start, 0);
      if (k == 3) chk("ap_start_lead_ok", apc >= START_GAP, 1);
    end
    repeat (3) @(negedge aclk);
    chk("ap_start_final", ap_start, r.exp_ap);
    chk("cfg_err_final", cfg_err, r.exp_err);
    chk("busy_final", busy, 0);
    quiet = 0;
    repeat (20) begin
      @(negedge aclk);
      quiet += int'(m_axi_awvalid | m_axi_wvalid | m_axi_bready);
    end
    chk("axi_quiet_after_seq", quiet, 0);
    chk("writes_all_seen", exp_q.size(), 0);
  endtask

  task automatic send_beat(input bit u, input bit l);
    fd_t e;
    int  g;
    bit  done;
    if (u) begin
      if (armed) begin
        e.w = last_w; e.h = line_m; e.ok = (last_w == cur_h) && (line_m == cur_v);
        fd_q.push_back(e);
      end
      armed  = 1'b1;
      line_m = l ? 16'd1 : 16'd0;
    end else if (l) begin
      line_m = line_m + 16'd1;
    end
    mon_tvalid = 1'b1; mon_tuser = u; mon_tlast = l;
    done = 1'b0; g = 0;
    while (!done) begin
      mon_tready = (g >= 8) || ($urandom_range(0, 3) != 0);
      @(posedge aclk);
      done = mon_tready;
      @(negedge aclk);
      g++;
    end
    mon_tvalid = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
  endtask

  task automatic send_line(input int width, input bit sof);
    for (int p = 0; p < width; p++) send_beat(sof && (p == 0), p == width - 1);
    chk("meas_width_after_tlast", meas_width, width);
    last_w = 16'(width);
    // idle cycle with sideband noise must not count as a beat
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tuser = 1'b1; mon_tlast = 1'b1;
    @(negedge aclk);
    mon_tready = 1'b0; mon_tuser = 1'b0; mon_tlast = 1'b0;
  endtask

  initial begin
    fd_t e;
    forever begin
      @(negedge aclk);
      if (frame_done) begin
        fd_cnt++;
        if (fd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL frame_done_unexpected: pulse seen, expected none");
        end else begin
          e = fd_q.pop_front();
          chk("fd_meas_width", meas_width, e.w);
          chk("fd_meas_height", meas_height, e.h);
          chk("fd_size_ok", size_ok, e.ok);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t rows[5];
    row_t srow;
    int   waited, apc, w;
    rows[0] = '{16'd480, 16'd640, 8'd9, 0, 0, 0, -1, 1'b1, 1'b0};
    rows[1] = '{16'd480, 16'd640, 8'd9, 3, 0, 1, -1, 1'b1, 1'b0};
    rows[2] = '{16'd100, 16'd200, 8'd3, 0, 2, 0, -1, 1'b1, 1'b0};
    rows[3] = '{16'd480, 16'd640, 8'd9, 0, 0, 0,  1, 1'b0, 1'b1};
    rows[4] = '{16'd33,  16'd17,  8'd5, 2, 2, 2,  3, 1'b1, 1'b1};
    srow    = '{16'd480, 16'd6,   8'd9, 1, 0, 0, -1, 1'b1, 1'b0};
    cfg_hsize = '0; cfg_vsize = '0; cfg_pattern = '0;

    for (int i = 0; i < 5; i++) begin
      apply_reset();
      release_and_write(rows[i]);
    end

    // reset while the WR_PAT write is pending, then a clean restart from WR_H
    apply_reset();
    cfg_hsize = 16'd480; cfg_vsize = 16'd640; cfg_pattern = 8'd9;
    exp_q.delete();
    exp_q.push_back({12'h010, 32'd640});
    exp_q.push_back({12'h018, 32'd480});
    aresetn = 1'b1;
    for (int k = 0; k < 2; k++) slave_write(0, 0, 0, 2'b00, waited, apc);
    w = 0;
    while (!m_axi_awvalid && w < 50) begin
      @(negedge aclk);
      w++;
    end
    chk("pat_aw_pending", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 12'h020});
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b0;
    #1 check_reset_outputs("async_reset_outputs");
    @(negedge aclk);
    release_and_write(rows[0]);

    // stream measurement: 480x6 frame, then a 479-wide frame, then a closing SOF
    apply_reset();
    fd_q.delete();
    fd_cnt = 0;
    armed = 1'b0; last_w = '0; line_m = '0;
    cur_h = srow.h; cur_v = srow.v;
    release_and_write(srow);
    for (int l = 0; l < 6; l++) send_line(480, l == 0);
    for (int l = 0; l < 6; l++) send_line(479, l == 0);
    send_beat(1'b1, 1'b0);
    repeat (5) @(negedge aclk);
    chk("frame_done_count", fd_cnt, 2);
    chk("frame_queue_drained", fd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
